// File: rtl/dmem_pkg.sv
// Shared sizing and types for the data memory.
// Build with DMEM_ERR_EN defined to add the addr_err output on data_memory.
package dmem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] word_t;

  // Widened by one bit so that DEPTH == 2**ADDR_W still compares correctly.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with a synchronous write/clear port and an asynchronous read index.
// Callers are expected to qualify write_en with the address range check.
module dmem_array
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [IDX_W-1:0] write_idx,
  input  word_t            write_data,
  input  logic [IDX_W-1:0] read_idx,
  output word_t            read_word
);

  word_t mem [DEPTH];

  // Reset clears every word and takes priority over any store on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[write_idx] <= write_data;
    end
  end

  assign read_word = mem[read_idx];

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory for the MEM stage: range check, read gating, error flag.
// Define DMEM_ERR_EN to add addr_err, flagging out-of-range accesses.
module data_memory
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] access_addr,
  input  word_t             write_data,
  output word_t             read_data
`ifdef DMEM_ERR_EN
  ,
  output logic              addr_err
`endif
);

  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             store;
  word_t            stored_word;

  assign in_range = addr_in_range(access_addr);
  assign idx      = access_addr[IDX_W-1:0];
  // Out-of-range stores are dropped here rather than wrapping onto idx.
  assign store    = write_en && in_range;

  dmem_array u_array (
    .clk        (clk),
    .rst        (rst),
    .write_en   (store),
    .write_idx  (idx),
    .write_data (write_data),
    .read_idx   (idx),
    .read_word  (stored_word)
  );

  assign read_data = (read_en && !rst && in_range) ? stored_word : '0;

`ifdef DMEM_ERR_EN
  assign addr_err = (read_en || write_en) && !rst && !in_range;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus a random sequence against a model.
// Expected read values are queued when inputs are driven and popped once the output settles.
module tb_data_memory;
  import dmem_pkg::*;

  logic              clk;
  logic              rst;
  logic              write_en;
  logic              read_en;
  logic [ADDR_W-1:0] access_addr;
  word_t             write_data;
  word_t             read_data;
`ifdef DMEM_ERR_EN
  logic              addr_err;
`endif

  word_t model [DEPTH];
  word_t exp_q [$];
  int    total;
  int    bad;

  data_memory dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .read_en     (read_en),
    .access_addr (access_addr),
    .write_data  (write_data),
    .read_data   (read_data)
`ifdef DMEM_ERR_EN
    ,
    .addr_err    (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Expected read_data from the model for the inputs currently driven.
  function automatic word_t modelRead();
    if (!read_en || rst || int'(access_addr) >= DEPTH) return '0;
    return model[access_addr[IDX_W-1:0]];
  endfunction

  task automatic pushExpect();
    exp_q.push_back(modelRead());
  endtask

  task automatic applyStimulus(input logic we, input logic re,
                               input logic [ADDR_W-1:0] addr, input word_t data);
    write_en    = we;
    read_en     = re;
    access_addr = addr;
    write_data  = data;
    pushExpect();
  endtask

  task automatic checkRead(input string tag);
    word_t e;
    #1;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput(tag, 32'(read_data), 32'(e));
    end
`ifdef DMEM_ERR_EN
    checkOutput({tag, "_err"}, 32'(addr_err),
                32'((read_en || write_en) && !rst && int'(access_addr) >= DEPTH));
`endif
  endtask

  // Advance one rising edge and mirror its effect in the model.
  task automatic clockEdge();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (write_en && int'(access_addr) < DEPTH) begin
      model[access_addr[IDX_W-1:0]] = write_data;
    end
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b1;
    write_en = 1'b0;
    read_en = 1'b0;
    access_addr = '0;
    write_data = '0;

    // Reset: two edges, read gated to zero while reset is held.
    clockEdge();
    clockEdge();
    applyStimulus(1'b0, 1'b1, 16'd3, '0);
    checkRead("reset_gate");
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 1'b1, 16'(a), '0);
      checkRead("reset_clear");
    end

    // Single store then immediate combinational load.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'd5, 16'd50);
    checkRead("wr5_rd_off");
    clockEdge();
    applyStimulus(1'b0, 1'b1, 16'd5, '0);
    checkRead("rd5");
    checkOutput("rd5_const", 32'(read_data), 32'd50);

    // Same-address read and write: old word before the edge, new after.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'd2, 16'hBEEF);
    checkRead("rw2_before");
    clockEdge();
    write_en = 1'b0;
    pushExpect();
    checkRead("rw2_after");
    checkOutput("rw2_after_const", 32'(read_data), 32'h0000BEEF);

    // Out-of-range store is dropped, no alias onto 300 mod 256 = 44.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'd300, 16'h1234);
    checkRead("oor_wr300");
    clockEdge();
    applyStimulus(1'b0, 1'b1, 16'd300, '0);
    checkRead("oor_rd300");
    applyStimulus(1'b0, 1'b1, 16'd44, '0);
    checkRead("alias_rd44");
    checkOutput("alias_rd44_const", 32'(read_data), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, '0);
    checkRead("oor_rd_max");
    applyStimulus(1'b0, 1'b1, 16'(DEPTH - 1), '0);
    checkRead("rd_last");

    // read_en low masks stored data; reset beats a concurrent store.
    applyStimulus(1'b0, 1'b0, 16'd5, '0);
    checkRead("rd_disabled");
    checkOutput("rd_disabled_const", 32'(read_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'd7, 16'd9);
    checkRead("rst_wr7");
    clockEdge();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'd5, '0);
    checkRead("post_rst_rd5");
    checkOutput("post_rst_rd5_const", 32'(read_data), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'd7, '0);
    checkRead("post_rst_rd7");

    // Random mixed traffic against the reference model.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    16'($urandom_range(0, 299)), 16'($urandom));
      checkRead("random");
      clockEdge();
    end
    write_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 1'b1, 16'(a), '0);
      checkRead("final_sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
